// File: rtl/definitions_pkg.sv
// Shared integer-datapath types and sizing for the writeback path.
package definitions_pkg;

    localparam int XLEN     = 32;
    localparam int WB_DEPTH = 4;

    typedef logic [4:0]      reg_e;
    typedef logic [XLEN-1:0] word_st;

    typedef struct packed {
        reg_e   rd_a;
        word_st rd_d;
    } wb_entry_st;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer with two ordered push ports (port 0 older) and one pop port.
// Exposes storage, per-slot valid mask and read pointer for the forwarding search.
module wb_fifo
    import definitions_pkg::*;
#(
    parameter  int DEPTH = WB_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push0_i,
    input  wb_entry_st             push0_e_i,
    input  logic                   push1_i,
    input  wb_entry_st             push1_e_i,
    input  logic                   pop_i,
    output wb_entry_st             head_o,
    output wb_entry_st [DEPTH-1:0] entries_o,
    output logic [DEPTH-1:0]       valid_o,
    output logic [PTR_W-1:0]       rd_ptr_o,
    output logic [CNT_W-1:0]       count_o
);

    wb_entry_st [DEPTH-1:0] mem_q;
    logic [DEPTH-1:0]       valid_q, valid_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, wr_ptr1;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;

    // Port 1 lands behind port 0 when both push; alone it takes the write slot.
    always_comb begin
        wr_ptr1  = push0_i ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        wr_ptr_d = wr_ptr_q + PTR_W'(push0_i) + PTR_W'(push1_i);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_i);
        count_d  = count_q + CNT_W'(push0_i) + CNT_W'(push1_i) - CNT_W'(pop_i);
        valid_d  = valid_q;
        if (pop_i)   valid_d[rd_ptr_q] = 1'b0;
        if (push0_i) valid_d[wr_ptr_q] = 1'b1;
        if (push1_i) valid_d[wr_ptr1]  = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push0_i) mem_q[wr_ptr_q] <= push0_e_i;
        if (push1_i) mem_q[wr_ptr1]  <= push1_e_i;
    end

    assign head_o    = mem_q[rd_ptr_q];
    assign entries_o = mem_q;
    assign valid_o   = valid_q;
    assign rd_ptr_o  = rd_ptr_q;
    assign count_o   = count_q;

endmodule

// File: rtl/writeback_queue.sv
// Register file write side: arbitrates ALU/LSU writebacks into an in-order queue,
// retires one entry per cycle and forwards still-pending values to decode.
module writeback_queue
    import definitions_pkg::*;
#(
    parameter  int DEPTH = WB_DEPTH,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             alu_valid_i,
    output logic             alu_ready_o,
    input  reg_e             alu_rd_a_i,
    input  word_st           alu_rd_d_i,
    input  logic             lsu_valid_i,
    output logic             lsu_ready_o,
    input  reg_e             lsu_rd_a_i,
    input  word_st           lsu_rd_d_i,
    output logic             rd_we_o,
    output reg_e             rd_a_o,
    output word_st           rd_d_o,
    input  reg_e             rs1_a_i,
    input  reg_e             rs2_a_i,
    output logic             rs1_hit_o,
    output word_st           rs1_d_o,
    output logic             rs2_hit_o,
    output word_st           rs2_d_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    wb_entry_st             alu_e, lsu_e, head, out_q, out_d;
    wb_entry_st [DEPTH-1:0] entries;
    logic [DEPTH-1:0]       valid;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count, free;
    logic                   alu_push, lsu_push, q_busy, f_push0, f_push1;
    logic                   rd_we_q, rd_we_d;

    assign free        = CNT_W'(DEPTH) - count;
    assign lsu_ready_o = (free != '0);
    assign alu_ready_o = (free >= CNT_W'(2)) | ((free == CNT_W'(1)) & !lsu_valid_i);

    // x0 requests are acknowledged but never take a slot.
    assign lsu_push = lsu_valid_i & lsu_ready_o & (lsu_rd_a_i != '0);
    assign alu_push = alu_valid_i & alu_ready_o & (alu_rd_a_i != '0);
    assign q_busy   = (count != '0);

    assign lsu_e.rd_a = lsu_rd_a_i;
    assign lsu_e.rd_d = lsu_rd_d_i;
    assign alu_e.rd_a = alu_rd_a_i;
    assign alu_e.rd_d = alu_rd_d_i;

    // With an empty queue the oldest incoming entry bypasses straight into the output register.
    assign f_push0 = q_busy & lsu_push;
    assign f_push1 = q_busy ? alu_push : (lsu_push & alu_push);

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push0_i   (f_push0),
        .push0_e_i (lsu_e),
        .push1_i   (f_push1),
        .push1_e_i (alu_e),
        .pop_i     (q_busy),
        .head_o    (head),
        .entries_o (entries),
        .valid_o   (valid),
        .rd_ptr_o  (rd_ptr),
        .count_o   (count)
    );

    always_comb begin
        rd_we_d = q_busy | lsu_push | alu_push;
        out_d   = out_q;
        if (q_busy)        out_d = head;
        else if (lsu_push) out_d = lsu_e;
        else if (alu_push) out_d = alu_e;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rd_we_q <= 1'b0;
            out_q   <= '0;
        end else begin
            rd_we_q <= rd_we_d;
            out_q   <= out_d;
        end
    end

    assign rd_we_o = rd_we_q;
    assign rd_a_o  = out_q.rd_a;
    assign rd_d_o  = out_q.rd_d;
    assign count_o = count;

    // Walk oldest to youngest so the youngest match overrides; output register ranks below all.
    function automatic logic [XLEN:0] fwd(input reg_e rs, input logic out_we, input wb_entry_st out_e,
                                          input wb_entry_st [DEPTH-1:0] ents, input logic [DEPTH-1:0] vld,
                                          input logic [PTR_W-1:0] rptr);
        logic             hit;
        word_st           d;
        logic [PTR_W-1:0] idx;
        hit = 1'b0;
        d   = '0;
        if (rs != '0) begin
            if (out_we && (out_e.rd_a == rs)) begin
                hit = 1'b1;
                d   = out_e.rd_d;
            end
            for (int i = 0; i < DEPTH; i++) begin
                idx = rptr + PTR_W'(i);
                if (vld[idx] && (ents[idx].rd_a == rs)) begin
                    hit = 1'b1;
                    d   = ents[idx].rd_d;
                end
            end
        end
        return {hit, d};
    endfunction

    assign {rs1_hit_o, rs1_d_o} = fwd(rs1_a_i, rd_we_q, out_q, entries, valid, rd_ptr);
    assign {rs2_hit_o, rs2_d_o} = fwd(rs2_a_i, rd_we_q, out_q, entries, valid, rd_ptr);

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue: per-cycle vector table plus backpressure and reset sequences.
module tb_writeback_queue;
    import definitions_pkg::*;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       alu_valid_i, alu_ready_o, lsu_valid_i, lsu_ready_o;
    reg_e       alu_rd_a_i, lsu_rd_a_i, rd_a_o, rs1_a_i, rs2_a_i;
    word_st     alu_rd_d_i, lsu_rd_d_i, rd_d_o, rs1_d_o, rs2_d_o;
    logic       rd_we_o, rs1_hit_o, rs2_hit_o;
    logic [2:0] count_o;

    always #5 clk_i = ~clk_i;

    writeback_queue dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .alu_valid_i (alu_valid_i),
        .alu_ready_o (alu_ready_o),
        .alu_rd_a_i  (alu_rd_a_i),
        .alu_rd_d_i  (alu_rd_d_i),
        .lsu_valid_i (lsu_valid_i),
        .lsu_ready_o (lsu_ready_o),
        .lsu_rd_a_i  (lsu_rd_a_i),
        .lsu_rd_d_i  (lsu_rd_d_i),
        .rd_we_o     (rd_we_o),
        .rd_a_o      (rd_a_o),
        .rd_d_o      (rd_d_o),
        .rs1_a_i     (rs1_a_i),
        .rs2_a_i     (rs2_a_i),
        .rs1_hit_o   (rs1_hit_o),
        .rs1_d_o     (rs1_d_o),
        .rs2_hit_o   (rs2_hit_o),
        .rs2_d_o     (rs2_d_o),
        .count_o     (count_o)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;
    wr_t wlog[$];

    always @(negedge clk_i) if (rd_we_o) wlog.push_back({rd_a_o, rd_d_o});

    typedef struct {
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        lv;
        logic [4:0]  la;
        logic [31:0] ld;
        logic [4:0]  r1, r2;
        logic        ardy, lrdy;
        logic [2:0]  cnt;
        logic        we;
        logic [4:0]  ra;
        logic [31:0] rd;
        logic        h1;
        logic [31:0] d1;
        logic        h2;
        logic [31:0] d2;
    } vec_t;

    localparam int NV = 14;
    vec_t vt[NV];

    function automatic vec_t mk(logic av, logic [4:0] aa, logic [31:0] ad,
                                logic lv, logic [4:0] la, logic [31:0] ld,
                                logic [4:0] r1, logic [4:0] r2,
                                logic ardy, logic lrdy, logic [2:0] cnt, logic we,
                                logic [4:0] ra, logic [31:0] rd,
                                logic h1, logic [31:0] d1, logic h2, logic [31:0] d2);
        vec_t v;
        v.av = av; v.aa = aa; v.ad = ad; v.lv = lv; v.la = la; v.ld = ld;
        v.r1 = r1; v.r2 = r2; v.ardy = ardy; v.lrdy = lrdy; v.cnt = cnt; v.we = we;
        v.ra = ra; v.rd = rd; v.h1 = h1; v.d1 = d1; v.h2 = h2; v.d2 = d2;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic lv, input logic [4:0] la, input logic [31:0] ld,
                         input logic [4:0] r1, input logic [4:0] r2);
        @(negedge clk_i);
        alu_valid_i = av; alu_rd_a_i = aa; alu_rd_d_i = ad;
        lsu_valid_i = lv; lsu_rd_a_i = la; lsu_rd_d_i = ld;
        rs1_a_i = r1; rs2_a_i = r2;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        //            av aa ad     lv la ld     r1 r2  ardy lrdy cnt we ra rd      h1 d1     h2 d2
        vt[0]  = mk(0, 0, 0,      0, 0, 0,      0, 0,  1, 1, 0, 0, 0, 0,      0, 0,     0, 0);
        vt[1]  = mk(1, 5, 'h11,   0, 0, 0,      5, 0,  1, 1, 0, 0, 0, 0,      0, 0,     0, 0);
        vt[2]  = mk(0, 0, 0,      0, 0, 0,      5, 5,  1, 1, 0, 1, 5, 'h11,   1, 'h11,  1, 'h11);
        vt[3]  = mk(1, 4, 'hBB,   1, 3, 'hAA,   3, 4,  1, 1, 0, 0, 5, 'h11,   0, 0,     0, 0);
        vt[4]  = mk(0, 0, 0,      0, 0, 0,      3, 4,  1, 1, 1, 1, 3, 'hAA,   1, 'hAA,  1, 'hBB);
        vt[5]  = mk(0, 0, 0,      0, 0, 0,      4, 3,  1, 1, 0, 1, 4, 'hBB,   1, 'hBB,  0, 0);
        vt[6]  = mk(1, 7, 2,      1, 7, 1,      7, 4,  1, 1, 0, 0, 4, 'hBB,   0, 0,     0, 0);
        vt[7]  = mk(0, 0, 0,      0, 0, 0,      7, 0,  1, 1, 1, 1, 7, 1,      1, 2,     0, 0);
        vt[8]  = mk(0, 0, 0,      0, 0, 0,      7, 0,  1, 1, 0, 1, 7, 2,      1, 2,     0, 0);
        vt[9]  = mk(1, 0, 'hFF,   0, 0, 0,      0, 7,  1, 1, 0, 0, 7, 2,      0, 0,     0, 0);
        vt[10] = mk(0, 0, 0,      0, 0, 0,      0, 0,  1, 1, 0, 0, 7, 2,      0, 0,     0, 0);
        vt[11] = mk(1, 9, 'h99,   1, 0, 'h55,   9, 0,  1, 1, 0, 0, 7, 2,      0, 0,     0, 0);
        vt[12] = mk(0, 0, 0,      0, 0, 0,      9, 0,  1, 1, 0, 1, 9, 'h99,   1, 'h99,  0, 0);
        vt[13] = mk(0, 0, 0,      0, 0, 0,      9, 0,  1, 1, 0, 0, 9, 'h99,   0, 0,     0, 0);

        rst_i = 1'b0;
        alu_valid_i = 0; alu_rd_a_i = '0; alu_rd_d_i = '0;
        lsu_valid_i = 0; lsu_rd_a_i = '0; lsu_rd_d_i = '0;
        rs1_a_i = '0; rs2_a_i = '0;
        repeat (3) @(negedge clk_i);
        chk("reset state", {count_o, rd_we_o, rd_a_o, rd_d_o, rs1_hit_o, rs2_hit_o}, '0);
        rst_i = 1'b1;

        for (int k = 0; k < NV; k++) begin
            drive(vt[k].av, vt[k].aa, vt[k].ad, vt[k].lv, vt[k].la, vt[k].ld, vt[k].r1, vt[k].r2);
            chk($sformatf("v%0d ctrl", k), {alu_ready_o, lsu_ready_o, count_o, rd_we_o},
                {vt[k].ardy, vt[k].lrdy, vt[k].cnt, vt[k].we});
            chk($sformatf("v%0d wport", k), {rd_a_o, rd_d_o}, {vt[k].ra, vt[k].rd});
            chk($sformatf("v%0d fwd", k), {rs1_hit_o, rs1_d_o, rs2_hit_o, rs2_d_o},
                {vt[k].h1, vt[k].d1, vt[k].h2, vt[k].d2});
        end

        // Backpressure: queue saturates at free=1, LSU wins, ALU goes next cycle, order intact.
        wlog.delete();
        drive(1, 2, 'h102, 1, 1, 'h101, 0, 0);
        drive(1, 4, 'h104, 1, 3, 'h103, 0, 0);
        chk("bp c1", {alu_ready_o, lsu_ready_o, count_o}, {1'b1, 1'b1, 3'd1});
        drive(1, 6, 'h106, 1, 5, 'h105, 0, 0);
        chk("bp c2", {alu_ready_o, lsu_ready_o, count_o}, {1'b1, 1'b1, 3'd2});
        drive(1, 8, 'h108, 1, 7, 'h107, 0, 0);
        chk("bp c3 lsu only", {alu_ready_o, lsu_ready_o, count_o}, {1'b0, 1'b1, 3'd3});
        drive(1, 8, 'h108, 0, 0, 0, 0, 0);
        chk("bp c4 alu next", {alu_ready_o, lsu_ready_o, count_o}, {1'b1, 1'b1, 3'd3});
        drive(0, 0, 0, 0, 0, 0, 7, 8);
        chk("bp c5 count", count_o, 3'd3);
        chk("bp c5 wport", {rd_we_o, rd_a_o, rd_d_o}, {1'b1, 5'd5, 32'h105});
        chk("bp c5 fwd", {rs1_hit_o, rs1_d_o, rs2_hit_o, rs2_d_o}, {1'b1, 32'h107, 1'b1, 32'h108});
        for (int i = 0; i < 20 && (count_o != 0 || rd_we_o); i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("bp drained", {count_o, rd_we_o}, '0);
        chk("bp write count", wlog.size(), 8);
        for (int i = 0; i < 8; i++)
            if (i < wlog.size())
                chk($sformatf("bp write %0d", i), wlog[i], {5'(i + 1), 32'h100 + 32'(i + 1)});

        // Reset while three entries are queued behind the output register.
        drive(1, 11, 'h211, 1, 10, 'h210, 0, 0);
        drive(1, 13, 'h213, 1, 12, 'h212, 0, 0);
        drive(1, 15, 'h215, 1, 14, 'h214, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 14, 15);
        chk("pre-reset count", count_o, 3'd3);
        rst_i = 1'b0;
        #1;
        chk("async reset", {count_o, rd_we_o, rd_a_o, rd_d_o}, '0);
        chk("reset fwd", {rs1_hit_o, rs2_hit_o}, '0);
        @(negedge clk_i);
        rst_i = 1'b1;
        wlog.delete();
        repeat (6) drive(0, 0, 0, 0, 0, 0, 14, 15);
        chk("post-reset writes", wlog.size(), 0);
        chk("post-reset state", {count_o, rd_we_o, rs1_hit_o, rs2_hit_o}, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
